// File: rtl/udp_tx_pkg.sv
// Shared constants, FSM state type and checksum folding helper for the UDP transmit framer.
package udp_tx_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [10:0] HDR_BYTES      = 11'd42;
  localparam logic [10:0] MIN_FRAME      = 11'd60;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  typedef enum logic [2:0] {IDLE, CSUM, FOLD, REQ, HDR, PAY, PAD} state_t;

  // Fold a 20-bit word sum twice so any carry out of the first fold is absorbed.
  function automatic logic [15:0] ones_fold(input logic [19:0] sum);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    s2 = s1[15:0] + {15'd0, s1[16]};
    return ~s2;
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// Sequential ones-complement summer for the ten 16-bit IPv4 header words.
module ip_hdr_csum
  import udp_tx_pkg::*;
(
  input  logic        clk125,
  input  logic        rst,
  input  logic        clr,
  input  logic        word_val,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc;

  // Accumulate header words; cleared while the framer is idle.
  always_ff @(posedge clk125) begin
    if (rst) begin
      acc <= 20'd0;
    end else if (clr) begin
      acc <= 20'd0;
    end else if (word_val) begin
      acc <= acc + {4'd0, word};
    end else begin
      acc <= acc;
    end
  end

  assign csum = ones_fold(acc);

endmodule

// File: rtl/udp_tx_framer.sv
// Builds an Ethernet II / IPv4 / UDP frame around a FWFT-FIFO payload and streams it to FrameL2_Out.
module udp_tx_framer
  import udp_tx_pkg::*;
#(
  parameter int          PAYLOAD_MAX = 1472,
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter logic [15:0] IP_ID_INIT  = 16'h0000
) (
  input  logic        clk125,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] len,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [15:0] src_port,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  input  logic [7:0]  pay_data,
  output logic        pay_rd,
  output logic        tx_req,
  input  logic        tx_grant,
  output logic        tx_val,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic        err_len
);

  state_t       state;
  state_t       byte_state;
  logic [10:0]  cnt;
  logic [10:0]  len_q;
  logic [47:0]  src_mac_q, dst_mac_q;
  logic [31:0]  src_ip_q, dst_ip_q;
  logic [15:0]  src_port_q, dst_port_q;
  logic [15:0]  ip_id;
  logic [15:0]  csum_q;
  logic [15:0]  sum_csum;
  logic [7:0]   data_q;
  logic [15:0]  total_len, udp_len, hdr_word;
  logic [10:0]  pay_end, frame_len;
  logic [335:0] hdr_vec;
  logic [7:0]   hdr_byte;
  logic         len_ok, is_hdr, is_pay, is_last;
  logic         csum_clr, csum_val;

  assign len_ok    = (len != 11'd0) && (len <= 11'(PAYLOAD_MAX));
  assign total_len = {5'd0, len_q} + 16'd28;
  assign udp_len   = {5'd0, len_q} + 16'd8;
  assign pay_end   = len_q + HDR_BYTES;
  assign frame_len = (pay_end < MIN_FRAME) ? MIN_FRAME : pay_end;
  assign is_hdr    = (cnt < HDR_BYTES);
  assign is_pay    = !is_hdr && (cnt < pay_end);
  assign is_last   = (cnt == frame_len - 11'd1);
  assign byte_state = is_hdr ? HDR : (is_pay ? PAY : PAD);

  // Full 42-byte header, MSB-first; byte i lives at bits [335-8i -: 8].
  assign hdr_vec = {dst_mac_q, src_mac_q, ETHERTYPE_IPV4, 8'h45, 8'h00, total_len, ip_id,
                    8'h40, 8'h00, IP_TTL, IP_PROTO_UDP, csum_q, src_ip_q, dst_ip_q,
                    src_port_q, dst_port_q, udp_len, 16'h0000};
  assign hdr_byte = hdr_vec[9'd328 - {cnt[5:0], 3'b000} +: 8];

  // Payload bytes bypass the output register so the FWFT head is popped in the same cycle it is shown.
  assign tx_data = pay_rd ? pay_data : data_q;

  assign csum_clr = (state == IDLE);
  assign csum_val = (state == CSUM);

  // Select the IPv4 header word fed to the checksum summer.
  always_comb begin
    hdr_word = 16'h0000;
    case (cnt[3:0])
      4'd0:    hdr_word = 16'h4500;
      4'd1:    hdr_word = total_len;
      4'd2:    hdr_word = ip_id;
      4'd3:    hdr_word = 16'h4000;
      4'd4:    hdr_word = {IP_TTL, IP_PROTO_UDP};
      4'd5:    hdr_word = 16'h0000;
      4'd6:    hdr_word = src_ip_q[31:16];
      4'd7:    hdr_word = src_ip_q[15:0];
      4'd8:    hdr_word = dst_ip_q[31:16];
      4'd9:    hdr_word = dst_ip_q[15:0];
      default: hdr_word = 16'h0000;
    endcase
  end

  ip_hdr_csum u_csum (
    .clk125   (clk125),
    .rst      (rst),
    .clr      (csum_clr),
    .word_val (csum_val),
    .word     (hdr_word),
    .csum     (sum_csum)
  );

  // Framer FSM with registered stream outputs.
  always_ff @(posedge clk125) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 11'd0;
      len_q      <= 11'd0;
      src_mac_q  <= 48'd0;
      dst_mac_q  <= 48'd0;
      src_ip_q   <= 32'd0;
      dst_ip_q   <= 32'd0;
      src_port_q <= 16'd0;
      dst_port_q <= 16'd0;
      ip_id      <= IP_ID_INIT;
      csum_q     <= 16'd0;
      data_q     <= 8'd0;
      pay_rd     <= 1'b0;
      tx_req     <= 1'b0;
      tx_val     <= 1'b0;
      tx_sof     <= 1'b0;
      tx_eof     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            len_q      <= len;
            src_mac_q  <= src_mac;
            dst_mac_q  <= dst_mac;
            src_ip_q   <= src_ip;
            dst_ip_q   <= dst_ip;
            src_port_q <= src_port;
            dst_port_q <= dst_port;
            cnt        <= 11'd0;
            busy       <= 1'b1;
            state      <= CSUM;
          end else if (start) begin
            err_len <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CSUM: begin
          if (cnt == 11'd9) begin
            state <= FOLD;
          end
          cnt <= cnt + 11'd1;
        end
        FOLD: begin
          csum_q <= sum_csum;
          tx_req <= 1'b1;
          cnt    <= 11'd0;
          state  <= REQ;
        end
        REQ: begin
          if (tx_grant) begin
            tx_req <= 1'b0;
            tx_sof <= 1'b1;
            tx_val <= 1'b1;
            tx_eof <= is_last;
            pay_rd <= is_pay;
            data_q <= is_hdr ? hdr_byte : 8'h00;
            state  <= byte_state;
            cnt    <= cnt + 11'd1;
          end
        end
        HDR, PAY, PAD: begin
          tx_sof <= 1'b0;
          if (cnt == frame_len) begin
            tx_val <= 1'b0;
            tx_eof <= 1'b0;
            pay_rd <= 1'b0;
            data_q <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b1;
            ip_id  <= ip_id + 16'd1;
            state  <= IDLE;
          end else begin
            tx_val <= 1'b1;
            tx_eof <= is_last;
            pay_rd <= is_pay;
            data_q <= is_hdr ? hdr_byte : 8'h00;
            state  <= byte_state;
            cnt    <= cnt + 11'd1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_req <= 1'b0;
          tx_val <= 1'b0;
          tx_sof <= 1'b0;
          tx_eof <= 1'b0;
          pay_rd <= 1'b0;
          data_q <= 8'h00;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed self-checking bench for udp_tx_framer: cycle-exact stream checks against hand-computed frames.
module tb_udp_tx_framer;

  logic        clk125 = 1'b0;
  logic        rst, start, tx_grant;
  logic [10:0] len;
  logic [47:0] src_mac, dst_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port;
  logic [7:0]  pay_data, pay_base;
  logic        pay_rd, tx_req, tx_val, tx_sof, tx_eof, busy, done, err_len;
  logic [7:0]  tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #4 clk125 = ~clk125;

  udp_tx_framer dut (
    .clk125(clk125), .rst(rst), .start(start), .len(len),
    .src_mac(src_mac), .src_ip(src_ip), .src_port(src_port),
    .dst_mac(dst_mac), .dst_ip(dst_ip), .dst_port(dst_port),
    .pay_data(pay_data), .pay_rd(pay_rd), .tx_req(tx_req), .tx_grant(tx_grant),
    .tx_val(tx_val), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_data(tx_data),
    .busy(busy), .done(done), .err_len(err_len)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {req,val,sof,eof,rd,busy,done,err,data}
  function automatic logic [15:0] outvec();
    return {tx_req, tx_val, tx_sof, tx_eof, pay_rd, busy, done, err_len, tx_data};
  endfunction

  task automatic do_reset();
    @(posedge clk125); #1; rst = 1'b1;
    @(posedge clk125); #1; rst = 1'b0;
  endtask

  task automatic try_bad(input logic [10:0] l);
    @(posedge clk125); #1; start = 1'b1; len = l;
    @(posedge clk125); #1; start = 1'b0; len = 11'd18;
    @(negedge clk125);
    check("err_len_pulse", 32'({busy, err_len, tx_req}), 32'd2);
    @(posedge clk125); #1;
    @(negedge clk125);
    check("err_len_clear", 32'({busy, err_len}), 32'd0);
  endtask

  // Start a frame in cycle 0; grant in cycle 12+gdly; optional reset at a byte and a stray start.
  task automatic run_frame(input logic [10:0] l, input int gdly, input logic [15:0] id,
                           input logic [15:0] csum, input int rst_byte, input int mid_start);
    logic [7:0]   expf [0:1513];
    logic [7:0]   cap  [0:1513];
    logic [335:0] hv;
    logic [15:0]  tl, ul, ev;
    logic         rd_seen, in_rst, e_val;
    int n, g, k, pidx, nrd, last, rst_cyc;
    tl = {5'd0, l} + 16'd28;
    ul = {5'd0, l} + 16'd8;
    n  = (42 + int'(l) < 60) ? 60 : 42 + int'(l);
    g  = 12 + gdly;
    hv = {dst_mac, src_mac, 16'h0800, 16'h4500, tl, id, 16'h4000, 8'd64, 8'h11, csum,
          src_ip, dst_ip, src_port, dst_port, ul, 16'h0000};
    for (int i = 0; i < n; i++) begin
      if (i < 42) expf[i] = hv[335 - 8*i -: 8];
      else if (i < 42 + int'(l)) expf[i] = pay_base + 8'(i - 42);
      else expf[i] = 8'h00;
    end
    rst_cyc = (rst_byte >= 0) ? g + 1 + rst_byte : -1;
    last    = (rst_cyc >= 0) ? rst_cyc + 3 : g + n + 2;
    pidx = 0; nrd = 0; rd_seen = 1'b0;
    pay_data = pay_base;
    @(posedge clk125); #1; start = 1'b1; len = l; tx_grant = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk125); #1;
      if (rd_seen) begin
        pidx++;
        pay_data = pay_base + 8'(pidx);
      end
      start    = (c == mid_start);
      len      = (c == mid_start) ? 11'd0 : l;
      tx_grant = (c == g) || (c > g && c % 3 == 0);
      rst      = (c == rst_cyc);
      @(negedge clk125);
      in_rst = (rst_cyc >= 0) && (c > rst_cyc);
      k      = c - g - 1;
      e_val  = !in_rst && c >= g + 1 && c <= g + n;
      ev = {(!in_rst && c >= 12 && c <= g), e_val, (e_val && c == g + 1), (e_val && c == g + n),
            (e_val && k >= 42 && k < 42 + int'(l)), (!in_rst && c <= g + n),
            (!in_rst && c == g + n + 1), 1'b0, (e_val ? expf[k] : 8'h00)};
      check("cycle", 32'(outvec()), 32'(ev));
      rd_seen = pay_rd;
      if (pay_rd) nrd++;
      if (tx_val && k >= 0 && k < 1514) cap[k] = tx_data;
    end
    rst = 1'b0; start = 1'b0; tx_grant = 1'b0;
    if (rst_byte < 0) begin
      check("total_len", 32'({cap[16], cap[17]}), 32'(tl));
      check("ip_id",     32'({cap[18], cap[19]}), 32'(id));
      check("ip_csum",   32'({cap[24], cap[25]}), 32'(csum));
      check("udp_len",   32'({cap[38], cap[39]}), 32'(ul));
      check("pay_rd_cnt", 32'(nrd), 32'(l));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tx_grant = 1'b0; len = 11'd0;
    pay_data = 8'h00; pay_base = 8'hA0;
    src_mac = 48'h02_00_00_00_00_05; dst_mac = 48'h02_00_00_00_00_01;
    src_ip  = 32'hC0A80505;          dst_ip  = 32'hC0A80501;
    src_port = 16'h1234;             dst_port = 16'h5678;
    repeat (3) @(posedge clk125);
    #1; rst = 1'b0;
    @(negedge clk125);
    check("reset_outputs", 32'(outvec()), 32'd0);

    run_frame(11'd18, 0, 16'h0000, 16'hAF68, -1, -1);
    do_reset();
    run_frame(11'd1, 3, 16'h0000, 16'hAF79, -1, -1);
    do_reset();
    run_frame(11'd18, 20, 16'h0000, 16'hAF68, -1, -1);

    try_bad(11'd0);
    try_bad(11'd1473);
    do_reset();
    pay_base = 8'h00;
    run_frame(11'd1472, 1, 16'h0000, 16'hA9BA, -1, -1);

    do_reset();
    pay_base = 8'h5A;
    run_frame(11'd18, 2, 16'h0000, 16'hAF68, -1, 20);
    run_frame(11'd18, 0, 16'h0001, 16'hAF67, -1, -1);

    do_reset();
    run_frame(11'd18, 0, 16'h0000, 16'hAF68, 30, -1);
    run_frame(11'd18, 0, 16'h0000, 16'hAF68, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
